// File: rtl/display_ctrl.sv
// Captures calculator digit frames into a double-buffered register file and scans an 8-digit common-anode display (DISPLAY_LZB_EN enables leading-zero blanking).
// Latency: active updates two edges after status goes ready; an/seg/dp are loaded at each prescaler terminal count.
// Backpressure: none, inputs are sampled every cycle and must be synchronous to clock.
module display_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, ERR} state_t;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] G_E     = 4'hA;
    localparam logic [3:0] G_R     = 4'hB;
    localparam logic [3:0] G_O     = 4'hC;
    localparam logic [3:0] G_BLANK = 4'hF;

    state_t          state;
    logic [7:0][3:0] shadow;
    logic [7:0][3:0] active;
    logic [PW-1:0]   presc;
    logic [2:0]      idx;
    logic [3:0]      glyph;
    logic            tc;
    logic            pos_ok;
    logic [2:0]      widx;
    logic [3:0]      wdat;
    logic            busy;

    assign pos_ok = (pos != 4'd0) && (pos <= 4'd8);
    assign widx   = 3'(pos - 4'd1);
    assign wdat   = (data > 4'd9) ? G_BLANK : data;
    assign tc     = (presc == PW'(SCAN_DIV - 1));
    assign busy   = (status == 2'b01) && (state != ERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            active <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (status == 2'b11) begin
                        shadow <= '0;
                        state  <= CAPTURE;
                    end else if (status == 2'b00) begin
                        state <= ERR;
                    end
                end
                CAPTURE: begin
                    case (status)
                        2'b11:   if (pos_ok) shadow[widx] <= wdat;
                        2'b10:   state <= COMMIT;
                        2'b00:   state <= ERR;
                        default: state <= CAPTURE;
                    endcase
                end
                COMMIT: begin
                    active <= shadow;
                    state  <= IDLE;
                end
                default: begin
                    if (status == 2'b11) begin
                        shadow <= '0;
                        state  <= CAPTURE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (tc) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

`ifdef DISPLAY_LZB_EN
    logic upper_zero;

    // True when this digit and everything above it hold zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if ((j >= int'(idx)) && (active[j] != 4'd0)) upper_zero = 1'b0;
        end
    end
`endif

    always_comb begin
        glyph = G_BLANK;
        if (state == ERR) begin
            case (idx)
                3'd3:        glyph = G_E;
                3'd2, 3'd1:  glyph = G_R;
                3'd0:        glyph = G_O;
                default:     glyph = G_BLANK;
            endcase
        end else begin
            glyph = active[idx];
`ifdef DISPLAY_LZB_EN
            if ((idx != 3'd0) && upper_zero) glyph = G_BLANK;
`endif
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] g);
        case (g)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            G_E:     seg_code = 7'h06;
            G_R:     seg_code = 7'h2F;
            G_O:     seg_code = 7'h23;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Outputs hold the current slot's digit until the next terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (tc) begin
            an  <= ~(8'd1 << idx);
            seg <= seg_code(glyph);
            dp  <= ~(busy && (idx == 3'd7));
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Randomized frame bench for display_ctrl against a digit-level display model.
module tb_display_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] status = 2'b10;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int failed = 0;

    int act_m[8];
    bit in_err = 0;
    int wp[$];
    int wd[$];
    logic [6:0] dig_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    display_ctrl #(.SCAN_DIV(2)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected glyph for digit i from the committed decimal value and mode.
    function automatic logic [6:0] exp_seg(input int i);
        int msd = 0;
        for (int j = 0; j < 8; j++) if (act_m[j] != 0) msd = j;
        if (in_err) begin
            if (i == 3) return 7'h06;
            if (i == 2 || i == 1) return 7'h2F;
            if (i == 0) return 7'h23;
            return 7'h7F;
        end
        if (act_m[i] > 9) return 7'h7F;
`ifdef DISPLAY_LZB_EN
        if (i > msd) return 7'h7F;
`endif
        return dig_seg[act_m[i]];
    endfunction

    task automatic scan_check(input string tag, input bit busy);
        logic [7:0] exp_an;
        repeat (20) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            exp_an = ~(8'd1 << i);
            while (an !== exp_an && n < 64) begin
                @(negedge clock);
                n++;
            end
            check($sformatf("%s_d%0d_an", tag, i), 32'(an), 32'(exp_an));
            check($sformatf("%s_d%0d_seg", tag, i), 32'(seg), 32'(exp_seg(i)));
            check($sformatf("%s_d%0d_dp", tag, i), 32'(dp), (busy && i == 7) ? 32'd0 : 32'd1);
        end
    endtask

    // Lead-in cycle, queued writes (optionally with busy gaps), then ready.
    task automatic run_frame(input bit busy_gaps);
        int sh[8];
        foreach (sh[k]) sh[k] = 0;
        @(negedge clock);
        status = 2'b11; pos = 4'd0; data = 4'd0;
        foreach (wp[k]) begin
            if (busy_gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clock);
                status = 2'b01; pos = 4'($urandom_range(1, 8)); data = 4'($urandom_range(0, 9));
            end
            @(negedge clock);
            status = 2'b11; pos = 4'(wp[k]); data = 4'(wd[k]);
            if (wp[k] >= 1 && wp[k] <= 8) sh[wp[k] - 1] = wd[k];
        end
        @(negedge clock);
        status = 2'b10; pos = 4'd0; data = 4'd0;
        act_m = sh;
        in_err = 0;
        wp.delete();
        wd.delete();
    endtask

    initial begin
        foreach (act_m[k]) act_m[k] = 0;
        repeat (2) @(negedge clock);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("pre_tc_an", 32'(an), 32'hFF);
        check("pre_tc_seg", 32'(seg), 32'h7F);
        @(negedge clock);
        check("first_tc_an", 32'(an), 32'hFE);
        check("first_tc_seg", 32'(seg), 32'h40);

        // 42
        wp = '{1, 2, 3, 4, 5, 6, 7, 8};
        wd = '{2, 4, 0, 0, 0, 0, 0, 0};
        run_frame(0);
        scan_check("v42", 0);

        // Error banner, then recovery with a 5
        wp = '{1}; wd = '{7};
        run_frame(0);
        scan_check("v7", 0);
        @(negedge clock); status = 2'b00;
        in_err = 1;
        scan_check("err", 0);
        @(negedge clock); status = 2'b10;
        scan_check("err_hold", 0);
        wp = '{1}; wd = '{5};
        run_frame(0);
        scan_check("v5", 0);

        // Ignored positions and overwrite
        wp = '{1, 0, 2, 9, 1, 15};
        wd = '{3, 9, 6, 5, 8, 1};
        run_frame(0);
        scan_check("ovr", 0);

        // Busy indicator
        @(negedge clock); status = 2'b01;
        scan_check("busy", 1);
        @(negedge clock); status = 2'b10;

        // Reset in the middle of a frame
        @(negedge clock); status = 2'b11; pos = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock); pos = 4'(k); data = 4'(k + 4);
        end
        #2 reset = 1'b1;
        #1;
        check("mid_rst_an", 32'(an), 32'hFF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'd1);
        @(negedge clock);
        status = 2'b10; pos = 4'd0; data = 4'd0;
        reset = 1'b0;
        foreach (act_m[k]) act_m[k] = 0;
        in_err = 0;
        scan_check("post_rst", 0);
        wp = '{1, 2, 3, 4, 5, 6, 7, 8};
        wd = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(0);
        scan_check("full", 0);

        // Random frames with busy gaps, out-of-range positions and stored blanks
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                wp.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8));
                wd.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            end
            run_frame(1);
            scan_check($sformatf("rnd%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Receiving end of the calculator's digit stream: captures the `data`/`pos`/`status` frames emitted by the calculator core into a double-buffered 8-digit register file and drives an 8-digit multiplexed common-anode 7-segment display. It sits between the calculator core and the board pins. It handles leading-zero blanking, the error banner and the busy indicator.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit scan slot; legal range ≥1.
- `clock`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `status`, input, 2: calculator state.
  - 00 = error.
  - 01 = busy.
  - 10 = ready.
  - 11 = printing.
- `data`, input, 4: BCD digit; values 10–15 are stored as blank.
- `pos`, input, 4: 1..8 marks a valid digit at index `pos-1` (index 0 = units); 0 and 9–15 are ignored.
- `an`, output, 8: anode enables, active-low; bit i drives digit i.
- `seg`, output, 7: {g,f,e,d,c,b,a}, active-low.
- `dp`, output, 1: decimal point, active-low.

## Operation
- Receive FSM states: IDLE, CAPTURE, COMMIT, ERR.
  - IDLE:
    - `status`==11 → CAPTURE, and all shadow entries are cleared to 0 on the same edge.
    - `status`==00 → ERR.
  - CAPTURE:
    - `status`==11 with `pos` in 1..8 → `shadow[pos-1]` <= `data`, or blank if `data` > 9.
    - `status`==10 → COMMIT.
    - `status`==00 → ERR.
    - `status`==01 → stay in CAPTURE; no write.
  - COMMIT: `active` <= `shadow` (all 8 entries in one cycle), then → IDLE unconditionally.
  - ERR:
    - The display shows "Erro" on digits 3..0 and blanks digits 7..4.
    - `active` is preserved.
    - Exit → CAPTURE (with shadow clear) only when `status`==11.
- Frame handling:
  - A short frame (fewer than 8 digits) still commits; positions never written stay 0.
  - A repeated `pos` overwrites; the last write wins.
- Busy: while `status`==01 and the FSM is not in ERR, `dp` is driven low on digit 7's scan slot only; the digits themselves are unchanged.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1.
  - At terminal count the prescaler reloads to 0 and the scan index advances 0→7, wrapping 7→0.
  - `an` = ~(1 << idx).
- Segment codes (hex, active-low):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Letters and blank: blank=7F, E=06, r=2F, o=23.
- Leading-zero blanking: every digit above the most significant nonzero `active` entry is shown blank. Digit 0 is always shown, so an all-zero value displays as "0".

## Timing
- Reset values:
  - `an`=FF, `seg`=7F, `dp`=1.
  - Scan index 0, prescaler 0.
  - `active` and `shadow` all 0.
  - FSM in IDLE.
- `an`, `seg` and `dp` are registered. They reflect the new scan index one cycle after the prescaler terminal count.
- Commit latency:
  - `status` goes to 10 on edge N.
  - The FSM reaches COMMIT on edge N+1.
  - `active` updates on edge N+2.
  - Each digit shows the new value at its next scan slot.
- Shadow writes take effect on the edge where the qualifier is true; there is no input registering, so inputs must be synchronous to `clock`.
- Double buffering: `active` never changes mid-frame, so no partial values are displayed.
- Reset mid-frame discards `shadow` and `active`, and the display blanks immediately (asynchronously).
- With `SCAN_DIV`=1 the scan index advances every cycle.
- The prescaler and scan index run continuously, independent of FSM state.

## Configuration
- `DISPLAY_LZB_EN` defined: leading-zero blanking active as described above.
- `DISPLAY_LZB_EN` undefined: all 8 digits are shown, including leading zeros ("00000042"). Stored blanks (`data` > 9) still display as blank.

## Test plan
- Reset released with `SCAN_DIV`=2 → `an`=FF, `seg`=7F, `dp`=1 until the first terminal count; then `an`=FE, `seg`=40.
- Frame with `status`=11 and `pos`=1..8 carrying `data`=2,4,0,0,0,0,0,0, then `status`=10 → `active` = 42 two cycles later.
  - With `DISPLAY_LZB_EN`: digit 0 `seg`=24, digit 1 `seg`=19, digits 2–7 `seg`=7F.
  - Without it: digits 2–7 `seg`=40.
- `status`=00 after a committed value of 7 → digits 3..0 show 06, 2F, 2F, 23 and digits 7..4 show 7F. A new frame with `data`=5 at `pos`=1, then `status`=10 → digit 0 shows 12.
- Frame with `pos`=0 and `pos`=9 writes interleaved with valid writes → the ignored writes leave `shadow` unchanged; a repeated write `pos`=1 with `data`=3 then `data`=8 commits 8.
- `status`=01 held → `dp`=0 only while `an`=7F, and the digit values are unchanged.
- Reset asserted while in CAPTURE after 4 digits → outputs return to reset values at once; the next full frame commits cleanly.
